// File: rtl/dallanma_yonlendirme_denetleyici_if.sv
// Branch-resolve / fetch-redirect bundle around the misprediction recovery controller.
interface dallanma_yonlendirme_denetleyici_if #(
  parameter int ADRES_GENISLIGI = 32,
  parameter int SAYAC_GENISLIGI = 16
);
  logic                       dallanma_gecerli_i;
  logic                       dallanma_hata_i;
  logic [ADRES_GENISLIGI-1:0] hedef_adres_i;
  logic                       durdur_i;
  logic                       getir_hazir_i;
  logic                       ps_yonlendir_gecerli_o;
  logic [ADRES_GENISLIGI-1:0] ps_yonlendir_o;
  logic                       bosalt_getir_o;
  logic                       bosalt_coz_o;
  logic                       dallanma_durdur_o;
  logic [SAYAC_GENISLIGI-1:0] hata_sayaci_o;

  modport slave (
    input  dallanma_gecerli_i, dallanma_hata_i, hedef_adres_i, durdur_i, getir_hazir_i,
    output ps_yonlendir_gecerli_o, ps_yonlendir_o, bosalt_getir_o, bosalt_coz_o,
           dallanma_durdur_o, hata_sayaci_o
  );

  modport master (
    output dallanma_gecerli_i, dallanma_hata_i, hedef_adres_i, durdur_i, getir_hazir_i,
    input  ps_yonlendir_gecerli_o, ps_yonlendir_o, bosalt_getir_o, bosalt_coz_o,
           dallanma_durdur_o, hata_sayaci_o
  );
endinterface

// File: rtl/dallanma_yonlendirme_denetleyici.sv
// Sequences recovery after a branch misprediction: latch target, redirect fetch
// with a valid/ready handshake, then hold fetch/decode flush for a fixed count.
module dallanma_yonlendirme_denetleyici #(
  parameter int ADRES_GENISLIGI = 32,
  parameter int BOSALTMA_CEVRIM = 2,
  parameter int SAYAC_GENISLIGI = 16
) (
  input logic clk_i,
  input logic rst_i,
  dallanma_yonlendirme_denetleyici_if.slave bus
);

  typedef enum logic [1:0] {
    BOSTA     = 2'd0,
    YONLENDIR = 2'd1,
    BOSALT    = 2'd2
  } durum_t;

  durum_t                     durum_q;
  durum_t                     durum_d;
  logic [3:0]                 bosaltma_q;
  logic [ADRES_GENISLIGI-1:0] adres_q;
  logic [SAYAC_GENISLIGI-1:0] sayac_q;
  logic                       yakala;
  logic                       aktar;

  always_comb begin
    durum_d = BOSTA;
    yakala  = 1'b0;
    aktar   = 1'b0;
    case (durum_q)
      BOSTA: begin
        durum_d = BOSTA;
        if (bus.dallanma_gecerli_i && bus.dallanma_hata_i && !bus.durdur_i) begin
          yakala  = 1'b1;
          durum_d = YONLENDIR;
        end
      end
      YONLENDIR: begin
        durum_d = YONLENDIR;
        if (bus.getir_hazir_i) begin
          aktar   = 1'b1;
          durum_d = BOSALT;
        end
      end
      BOSALT: begin
        durum_d = BOSALT;
        if (!bus.durdur_i && bosaltma_q == 4'd1) begin
          durum_d = BOSTA;
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  // Flush counter only moves on unstalled cycles so stalls stretch the flush window.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q    <= BOSTA;
      bosaltma_q <= 4'd0;
      adres_q    <= '0;
      sayac_q    <= '0;
    end else begin
      durum_q <= durum_d;
      if (yakala) begin
        adres_q <= bus.hedef_adres_i;
        if (sayac_q != '1) begin
          sayac_q <= sayac_q + 1'b1;
        end
      end
      if (aktar) begin
        bosaltma_q <= 4'(BOSALTMA_CEVRIM);
      end else if (durum_q == BOSALT && !bus.durdur_i) begin
        bosaltma_q <= bosaltma_q - 4'd1;
      end
    end
  end

  assign bus.ps_yonlendir_gecerli_o = (durum_q == YONLENDIR);
  assign bus.ps_yonlendir_o         = adres_q;
  assign bus.bosalt_getir_o         = (durum_q == YONLENDIR) || (durum_q == BOSALT);
  assign bus.bosalt_coz_o           = (durum_q == YONLENDIR) || (durum_q == BOSALT);
  assign bus.dallanma_durdur_o      = (durum_q == YONLENDIR) || (durum_q == BOSALT);
  assign bus.hata_sayaci_o          = sayac_q;

endmodule

// File: tb/tb_dallanma_yonlendirme_denetleyici.sv
// Directed bench for the misprediction recovery controller; a narrow counter
// keeps the saturation scenario short.
module tb_dallanma_yonlendirme_denetleyici;

  localparam int AG = 32;
  localparam int SG = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [SG-1:0] exp_sayac;

  dallanma_yonlendirme_denetleyici_if #(.ADRES_GENISLIGI(AG), .SAYAC_GENISLIGI(SG)) bus();

  dallanma_yonlendirme_denetleyici #(
    .ADRES_GENISLIGI(AG),
    .BOSALTMA_CEVRIM(2),
    .SAYAC_GENISLIGI(SG)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic gecerli, input logic hata, input logic [AG-1:0] hedef,
                               input logic durdur, input logic hazir);
    bus.dallanma_gecerli_i = gecerli;
    bus.dallanma_hata_i    = hata;
    bus.hedef_adres_i      = hedef;
    bus.durdur_i           = durdur;
    bus.getir_hazir_i      = hazir;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic valid, input logic [AG-1:0] ps,
                             input logic flush, input logic [SG-1:0] sayac);
    checkValue({tag, ".valid"}, 32'(bus.ps_yonlendir_gecerli_o), 32'(valid));
    checkValue({tag, ".ps"},    bus.ps_yonlendir_o, ps);
    checkValue({tag, ".getir"}, 32'(bus.bosalt_getir_o), 32'(flush));
    checkValue({tag, ".coz"},   32'(bus.bosalt_coz_o), 32'(flush));
    checkValue({tag, ".busy"},  32'(bus.dallanma_durdur_o), 32'(flush));
    checkValue({tag, ".sayac"}, 32'(bus.hata_sayaci_o), 32'(sayac));
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] reset");
    step();
    step();
    checkOutput("reset", 1'b0, 32'h0, 1'b0, 4'd0);
    rst_i = 1'b0;
    step();
    checkOutput("reset_idle", 1'b0, 32'h0, 1'b0, 4'd0);

    $display("[TB] basic mispredict");
    applyStimulus(1'b1, 1'b1, 32'h0000_1040, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("mp_redirect", 1'b1, 32'h1040, 1'b1, 4'd1);
    step();
    checkOutput("mp_flush1", 1'b0, 32'h1040, 1'b1, 4'd1);
    step();
    checkOutput("mp_flush2", 1'b0, 32'h1040, 1'b1, 4'd1);
    step();
    checkOutput("mp_idle", 1'b0, 32'h1040, 1'b0, 4'd1);

    applyStimulus(1'b1, 1'b0, 32'h0000_7777, 1'b0, 1'b1);
    step();
    checkOutput("correct_pred", 1'b0, 32'h1040, 1'b0, 4'd1);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 1'b1, 32'h0000_1040, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0000_2000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_hold%0d", i), 1'b1, 32'h1040, 1'b1, 4'd2);
      if (i == 4) bus.getir_hazir_i = 1'b1;
      step();
    end
    checkOutput("bp_flush1", 1'b0, 32'h1040, 1'b1, 4'd2);
    step();
    checkOutput("bp_flush2", 1'b0, 32'h1040, 1'b1, 4'd2);
    step();
    checkOutput("bp_idle", 1'b0, 32'h1040, 1'b0, 4'd2);

    $display("[TB] stall and wrong-path");
    applyStimulus(1'b1, 1'b1, 32'h0000_3000, 1'b1, 1'b1);
    step();
    checkOutput("stall_block", 1'b0, 32'h1040, 1'b0, 4'd2);
    bus.durdur_i = 1'b0;
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("stall_capture", 1'b1, 32'h3000, 1'b1, 4'd3);
    step();
    checkOutput("stall_bosalt", 1'b0, 32'h3000, 1'b1, 4'd3);
    applyStimulus(1'b1, 1'b1, 32'h0000_4000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("stall_frozen%0d", i), 1'b0, 32'h3000, 1'b1, 4'd3);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step();
    checkOutput("stall_last", 1'b0, 32'h3000, 1'b1, 4'd3);
    step();
    checkOutput("stall_idle", 1'b0, 32'h3000, 1'b0, 4'd3);

    $display("[TB] saturation");
    exp_sayac = 4'd3;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h0000_5000 + 32'(i), 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      exp_sayac = (exp_sayac == 4'hF) ? 4'hF : exp_sayac + 4'd1;
      checkValue($sformatf("sat_count%0d", i), 32'(bus.hata_sayaci_o), 32'(exp_sayac));
      step();
      step();
      step();
    end
    checkOutput("sat_final", 1'b0, 32'h0000_500C, 1'b0, 4'hF);

    $display("[TB] reset mid-redirect");
    applyStimulus(1'b1, 1'b1, 32'h0000_6000, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("mid_redirect", 1'b1, 32'h6000, 1'b1, 4'hF);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    checkOutput("mid_reset", 1'b0, 32'h0, 1'b0, 4'd0);
    step();
    checkOutput("mid_after", 1'b0, 32'h0, 1'b0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
